// File: rtl/axi_lite_master_mux_if.sv
// AXI4-lite bundle shared by the upstream masters and the downstream port of
// axi_lite_master_mux. "master" is the side that issues addresses and data;
// "slave" is the side that accepts them and returns responses.
interface axi_lite_master_mux_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb,    input wready,
    input  bvalid, bresp,           output bready,
    output arvalid, araddr, arprot, input arready,
    input  rvalid, rdata, rresp,    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb,    output wready,
    output bvalid, bresp,           input bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp,    input rready
  );
endinterface

// File: rtl/axi_lite_master_mux.sv
// 2:1 AXI4-lite arbiter: upstream masters s0/s1 share the downstream port m.
// One transaction in flight; reads win over writes inside the granted master.
// Optional macro ARB_FIXED_PRIO_EN: s0 always wins a tie instead of round-robin.
module axi_lite_master_mux (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_master_mux_if.slave  s0,
  axi_lite_master_mux_if.slave  s1,
  axi_lite_master_mux_if.master m,
  output logic                  grant_id,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

  state_t state, state_nxt;
  logic   last_id, aw_done, w_done;
  logic   req0, req1, gnt_nxt, gnt_arvalid;
  logic   sel_awvalid, sel_wvalid, sel_arvalid, sel_rready, sel_bready;
  logic   sel_awready, sel_wready, sel_arready, sel_rvalid, sel_bvalid;
  logic   m_awvalid, m_wvalid, m_arvalid, m_rready, m_bready;
  logic   aw_fire, w_fire, xfer_done;

  assign req0 = s0.arvalid | s0.awvalid;
  assign req1 = s1.arvalid | s1.awvalid;

`ifdef ARB_FIXED_PRIO_EN
  assign gnt_nxt = ~req0;
`else
  // Tie goes to whoever was not served last.
  assign gnt_nxt = (req0 & req1) ? ~last_id : req1;
`endif
  assign gnt_arvalid = gnt_nxt ? s1.arvalid : s0.arvalid;

  // Upstream-side controls of the granted master.
  assign sel_awvalid = grant_id ? s1.awvalid : s0.awvalid;
  assign sel_wvalid  = grant_id ? s1.wvalid  : s0.wvalid;
  assign sel_arvalid = grant_id ? s1.arvalid : s0.arvalid;
  assign sel_rready  = grant_id ? s1.rready  : s0.rready;
  assign sel_bready  = grant_id ? s1.bready  : s0.bready;

  // Payload always follows the grant so nothing floats to X when idle.
  assign m.awaddr = grant_id ? s1.awaddr : s0.awaddr;
  assign m.awprot = grant_id ? s1.awprot : s0.awprot;
  assign m.wdata  = grant_id ? s1.wdata  : s0.wdata;
  assign m.wstrb  = grant_id ? s1.wstrb  : s0.wstrb;
  assign m.araddr = grant_id ? s1.araddr : s0.araddr;
  assign m.arprot = grant_id ? s1.arprot : s0.arprot;
  assign s0.rdata = m.rdata;
  assign s0.rresp = m.rresp;
  assign s0.bresp = m.bresp;
  assign s1.rdata = m.rdata;
  assign s1.rresp = m.rresp;
  assign s1.bresp = m.bresp;

  assign m.awvalid = m_awvalid;
  assign m.wvalid  = m_wvalid;
  assign m.arvalid = m_arvalid;
  assign m.rready  = m_rready;
  assign m.bready  = m_bready;

  // Handshake outputs reach only the granted master; the other sees zeros.
  assign s0.awready = ~grant_id & sel_awready;
  assign s0.wready  = ~grant_id & sel_wready;
  assign s0.arready = ~grant_id & sel_arready;
  assign s0.rvalid  = ~grant_id & sel_rvalid;
  assign s0.bvalid  = ~grant_id & sel_bvalid;
  assign s1.awready =  grant_id & sel_awready;
  assign s1.wready  =  grant_id & sel_wready;
  assign s1.arready =  grant_id & sel_arready;
  assign s1.rvalid  =  grant_id & sel_rvalid;
  assign s1.bvalid  =  grant_id & sel_bvalid;

  assign busy = (state != IDLE);

  // Next state and per-state channel routing; only the active channel opens.
  always_comb begin
    state_nxt   = state;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_bready    = 1'b0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_bvalid  = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    xfer_done   = 1'b0;
    case (state)
      IDLE: if (req0 | req1) state_nxt = gnt_arvalid ? RD_ADDR : WR_ADDR;
      RD_ADDR: begin
        m_arvalid   = sel_arvalid;
        sel_arready = m.arready;
        if (sel_arvalid & m.arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        m_rready   = sel_rready;
        sel_rvalid = m.rvalid;
        xfer_done  = m.rvalid & sel_rready;
        if (xfer_done) state_nxt = IDLE;
      end
      WR_ADDR: begin
        // AW and W complete independently; a finished channel is masked off.
        m_awvalid   = sel_awvalid & ~aw_done;
        sel_awready = m.awready & ~aw_done;
        m_wvalid    = sel_wvalid & ~w_done;
        sel_wready  = m.wready & ~w_done;
        aw_fire     = m_awvalid & m.awready;
        w_fire      = m_wvalid & m.wready;
        if ((aw_done | aw_fire) & (w_done | w_fire)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_bready   = sel_bready;
        sel_bvalid = m.bvalid;
        xfer_done  = m.bvalid & sel_bready;
        if (xfer_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and write-progress registers; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= 1'b0;
      last_id  <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req0 | req1)) grant_id <= gnt_nxt;
      if (xfer_done) last_id <= grant_id;
      aw_done <= (state == WR_ADDR) && (state_nxt == WR_ADDR) && (aw_done | aw_fire);
      w_done  <= (state == WR_ADDR) && (state_nxt == WR_ADDR) && (w_done | w_fire);
    end
  end
endmodule

// File: tb/tb_axi_lite_master_mux.sv
// Directed bench for axi_lite_master_mux: reset, single read, reset during a
// read, arbitration between two readers, and a write with W ahead of AW.
module tb_axi_lite_master_mux;
  logic clk, rst;
  logic grant_id, busy;
  int   n_chk, n_fail;

  axi_lite_master_mux_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_if ();
  axi_lite_master_mux_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_if ();
  axi_lite_master_mux_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axi_lite_master_mux dut (
    .clk      (clk),
    .rst      (rst),
    .s0       (s0_if),
    .s1       (s1_if),
    .m        (m_if),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the mux in RD_ADDR for master id.
  task automatic serve_read(input bit id, input logic [31:0] exp_addr, input logic [31:0] rd);
    #1;
    chk("rd grant_id", grant_id, id);
    chk("m arvalid", m_if.arvalid, 1);
    chk("m araddr", m_if.araddr, exp_addr);
    m_if.arready = 1'b1;
    #1;
    chk("granted arready", id ? s1_if.arready : s0_if.arready, 1);
    chk("other arready", id ? s0_if.arready : s1_if.arready, 0);
    @(negedge clk);
    m_if.arready = 1'b0;
    if (id) s1_if.arvalid = 1'b0; else s0_if.arvalid = 1'b0;
    m_if.rvalid = 1'b1;
    m_if.rdata  = rd;
    m_if.rresp  = 2'b00;
    s0_if.rready = 1'b1;
    s1_if.rready = 1'b1;
    #1;
    chk("granted rvalid", id ? s1_if.rvalid : s0_if.rvalid, 1);
    chk("granted rdata", id ? s1_if.rdata : s0_if.rdata, rd);
    chk("other rvalid", id ? s0_if.rvalid : s1_if.rvalid, 0);
    chk("m arvalid in rd_data", m_if.arvalid, 0);
    @(negedge clk);
    m_if.rvalid  = 1'b0;
    s0_if.rready = 1'b0;
    s1_if.rready = 1'b0;
    #1;
    chk("busy after read", busy, 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    s0_if.awvalid = 0; s0_if.awaddr = 0; s0_if.awprot = 0; s0_if.wvalid = 0;
    s0_if.wdata = 0; s0_if.wstrb = 0; s0_if.bready = 0; s0_if.arvalid = 0;
    s0_if.araddr = 0; s0_if.arprot = 0; s0_if.rready = 0;
    s1_if.awvalid = 0; s1_if.awaddr = 0; s1_if.awprot = 0; s1_if.wvalid = 0;
    s1_if.wdata = 0; s1_if.wstrb = 0; s1_if.bready = 0; s1_if.arvalid = 0;
    s1_if.araddr = 0; s1_if.arprot = 0; s1_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0;

    // Reset for two cycles.
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset m arvalid", m_if.arvalid, 0);
    chk("reset m awvalid", m_if.awvalid, 0);
    chk("reset m wvalid", m_if.wvalid, 0);
    chk("reset m rready", m_if.rready, 0);
    chk("reset m bready", m_if.bready, 0);
    chk("reset s0 arready", s0_if.arready, 0);
    chk("reset s1 bvalid", s1_if.bvalid, 0);
    rst = 1'b0;

    // Single S0 read; AR reaches M one cycle after the request.
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'h0000_ABAC;
    s0_if.arprot  = 3'b101;
    #1;
    chk("arb latency m arvalid", m_if.arvalid, 0);
    chk("arb latency busy", busy, 0);
    @(negedge clk);
    #1;
    chk("m arprot passthrough", m_if.arprot, 3'b101);
    chk("s1 arready untouched", s1_if.arready, 0);
    serve_read(1'b0, 32'h0000_ABAC, 32'hDEAD_AAAA);

    // Reset while S1 waits in RD_DATA aborts the read.
    @(negedge clk);
    s1_if.arvalid = 1'b1;
    s1_if.araddr  = 32'h0000_0300;
    @(negedge clk);
    #1;
    chk("abort grant_id", grant_id, 1);
    m_if.arready = 1'b1;
    @(negedge clk);
    m_if.arready  = 1'b0;
    s1_if.arvalid = 1'b0;
    s1_if.rready  = 1'b1;
    #1;
    chk("rd_data m rready", m_if.rready, 1);
    rst = 1'b1;
    m_if.rvalid = 1'b1;
    @(negedge clk);
    #1;
    chk("abort busy", busy, 0);
    chk("abort m rready", m_if.rready, 0);
    chk("abort s1 rvalid", s1_if.rvalid, 0);
    chk("abort grant_id reset", grant_id, 0);
    rst = 1'b0;
    m_if.rvalid  = 1'b0;
    s1_if.rready = 1'b0;

    // Both masters request reads in the same cycle.
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'h0000_0100;
    s1_if.arvalid = 1'b1;
    s1_if.araddr  = 32'h0000_0200;
    @(negedge clk);
    serve_read(1'b0, 32'h0000_0100, 32'h1111_0000);
`ifdef ARB_FIXED_PRIO_EN
    // S0 keeps requesting: S1 must keep waiting.
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'h0000_0104;
    @(negedge clk);
    serve_read(1'b0, 32'h0000_0104, 32'h1111_0004);
    @(negedge clk);
    serve_read(1'b1, 32'h0000_0200, 32'h2222_0000);
`else
    // Round-robin alternation while both keep requesting.
    s0_if.arvalid = 1'b1;
    s0_if.araddr  = 32'h0000_0104;
    @(negedge clk);
    serve_read(1'b1, 32'h0000_0200, 32'h2222_0000);
    s1_if.arvalid = 1'b1;
    s1_if.araddr  = 32'h0000_0204;
    @(negedge clk);
    serve_read(1'b0, 32'h0000_0104, 32'h1111_0004);
    @(negedge clk);
    serve_read(1'b1, 32'h0000_0204, 32'h2222_0004);
`endif

    // S1 write with W presented two cycles before AW.
    @(negedge clk);
    s1_if.wvalid = 1'b1;
    s1_if.wdata  = 32'h1234_5678;
    s1_if.wstrb  = 4'hF;
    #1;
    chk("w only busy", busy, 0);
    chk("w only m wvalid", m_if.wvalid, 0);
    @(negedge clk);
    #1;
    chk("w only still idle", busy, 0);
    @(negedge clk);
    s1_if.awvalid = 1'b1;
    s1_if.awaddr  = 32'h0000_0040;
    s1_if.awprot  = 3'b010;
    #1;
    chk("aw latency m awvalid", m_if.awvalid, 0);
    @(negedge clk);
    #1;
    chk("wr grant_id", grant_id, 1);
    chk("m awvalid", m_if.awvalid, 1);
    chk("m awaddr", m_if.awaddr, 32'h0000_0040);
    chk("m awprot", m_if.awprot, 3'b010);
    chk("m wvalid", m_if.wvalid, 1);
    chk("m wdata", m_if.wdata, 32'h1234_5678);
    chk("m wstrb", m_if.wstrb, 4'hF);
    m_if.wready = 1'b1;
    #1;
    chk("s1 wready", s1_if.wready, 1);
    chk("s1 awready early", s1_if.awready, 0);
    @(negedge clk);
    m_if.wready  = 1'b0;
    m_if.awready = 1'b1;
    #1;
    chk("w masked after done", m_if.wvalid, 0);
    chk("m awvalid pending", m_if.awvalid, 1);
    chk("s1 awready", s1_if.awready, 1);
    @(negedge clk);
    m_if.awready  = 1'b0;
    s1_if.awvalid = 1'b0;
    s1_if.wvalid  = 1'b0;
    m_if.bvalid   = 1'b1;
    m_if.bresp    = 2'b00;
    s1_if.bready  = 1'b1;
    #1;
    chk("wr_resp m awvalid", m_if.awvalid, 0);
    chk("wr_resp m bready", m_if.bready, 1);
    chk("s1 bvalid", s1_if.bvalid, 1);
    chk("s1 bresp", s1_if.bresp, 2'b00);
    chk("s0 bvalid", s0_if.bvalid, 0);
    @(negedge clk);
    m_if.bvalid  = 1'b0;
    s1_if.bready = 1'b0;
    #1;
    chk("busy after write", busy, 0);
    chk("m bready after write", m_if.bready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
